// File: rtl/bus_pkg.sv
// Shared types for the 8085 bus-cycle sequencer: cycle codes, sequencer states,
// one-hot T-state encodings seen by decoding, and status helpers.
package bus_pkg;

    localparam int unsigned CYC_TYPE_W = 3;
    localparam int unsigned TSTATE_W   = 7;

    typedef enum logic [CYC_TYPE_W-1:0] {
        CYC_M1  = 3'd0,
        CYC_MR  = 3'd1,
        CYC_MW  = 3'd2,
        CYC_IOR = 3'd3,
        CYC_IOW = 3'd4
    } cyc_type_e;

    typedef enum logic [3:0] {
        ST_TRESET = 4'd0,
        ST_IDLE   = 4'd1,
        ST_T1     = 4'd2,
        ST_T2     = 4'd3,
        ST_TWAIT  = 4'd4,
        ST_T3     = 4'd5,
        ST_T4     = 4'd6,
        ST_T5     = 4'd7,
        ST_T6     = 4'd8,
        ST_THOLD  = 4'd9
    } bus_state_e;

    // One-hot T-state codes handed to the decoding stage
    localparam logic [TSTATE_W-1:0] TS_T1     = 7'b1000000;
    localparam logic [TSTATE_W-1:0] TS_T2     = 7'b0100000;
    localparam logic [TSTATE_W-1:0] TS_T3     = 7'b0010000;
    localparam logic [TSTATE_W-1:0] TS_T4     = 7'b0001000;
    localparam logic [TSTATE_W-1:0] TS_T5     = 7'b0000100;
    localparam logic [TSTATE_W-1:0] TS_T6     = 7'b0000010;
    localparam logic [TSTATE_W-1:0] TS_TRESET = 7'b0000001;
    localparam logic [TSTATE_W-1:0] TS_NONE   = 7'b0000000;

    function automatic logic cyc_type_legal(logic [CYC_TYPE_W-1:0] code);
        return code <= 3'd4;
    endfunction

    // Status triple {IOMn, S1, S0} driven for the whole machine cycle
    function automatic logic [2:0] cyc_status(cyc_type_e t);
        logic [2:0] sts;
        case (t)
            CYC_M1:  sts = 3'b011;
            CYC_MR:  sts = 3'b010;
            CYC_MW:  sts = 3'b001;
            CYC_IOR: sts = 3'b110;
            CYC_IOW: sts = 3'b101;
            default: sts = 3'b000;
        endcase
        return sts;
    endfunction

    function automatic logic cyc_is_read(cyc_type_e t);
        return (t == CYC_M1) || (t == CYC_MR) || (t == CYC_IOR);
    endfunction

    function automatic logic cyc_is_io(cyc_type_e t);
        return (t == CYC_IOR) || (t == CYC_IOW);
    endfunction

    // True in the final T-state of a machine cycle
    function automatic logic is_last_t(bus_state_e s, cyc_type_e t, logic lng);
        logic last;
        case (s)
            ST_T3:   last = (t != CYC_M1);
            ST_T4:   last = (t == CYC_M1) && !lng;
            ST_T6:   last = 1'b1;
            default: last = 1'b0;
        endcase
        return last;
    endfunction

endpackage

// File: rtl/bus_cycle_unit.sv
// 8085 external bus sequencer: runs one machine cycle per accepted request,
// drives the multiplexed AD bus and strobes, handles READY waits and HOLD.
module bus_cycle_unit
    import bus_pkg::*;
#(
    parameter int unsigned RESET_CYCLES = 3,
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned DATA_W       = 8
) (
    input  logic              phi1,
    input  logic              reset,
    input  logic              cyc_start,
    input  logic [2:0]        cyc_type,
    input  logic              cyc_long,
    input  logic [ADDR_W-1:0] cyc_addr,
    input  logic [DATA_W-1:0] cyc_wdata,
    input  logic [DATA_W-1:0] ad_in,
    input  logic              ready,
    input  logic              hold,
    output logic [7:0]        a_hi,
    output logic [DATA_W-1:0] ad_out,
    output logic              ad_oe,
    output logic              ALE,
    output logic              RDn,
    output logic              WRn,
    output logic              IOMn,
    output logic              S0,
    output logic              S1,
    output logic              hlda,
    output logic [6:0]        cur_t,
    output logic [DATA_W-1:0] instr_out,
    output logic              instr_valid,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              cyc_done,
    output logic              busy
);

    localparam int unsigned RST_CNT_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int unsigned AHI_W     = 8;

    bus_state_e            state_q, state_d, end_state;
    cyc_type_e             typ_q, typ_d;
    logic                  long_q, long_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [RST_CNT_W-1:0]  rst_cnt_q, rst_cnt_d;
    logic                  last_q, accept;
    logic                  cap_instr, cap_read;

    logic                  ale_d, rdn_d, wrn_d, ad_oe_d, hlda_d, busy_d, done_d;
    logic [2:0]            sts_d;
    logic [DATA_W-1:0]     ad_out_d;
    logic [AHI_W-1:0]      a_hi_d;
    logic [TSTATE_W-1:0]   cur_t_d;

    // Read data is sampled on the edge that leaves T3
    assign cap_instr = (state_q == ST_T3) && (typ_q == CYC_M1);
    assign cap_read  = (state_q == ST_T3) && ((typ_q == CYC_MR) || (typ_q == CYC_IOR));

    // State and registered outputs
    always_ff @(posedge phi1) begin
        if (!reset) begin
            state_q     <= ST_TRESET;
            rst_cnt_q   <= '0;
            typ_q       <= CYC_M1;
            long_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            ALE         <= 1'b0;
            RDn         <= 1'b1;
            WRn         <= 1'b1;
            IOMn        <= 1'b0;
            S1          <= 1'b0;
            S0          <= 1'b0;
            ad_oe       <= 1'b0;
            ad_out      <= '0;
            a_hi        <= '0;
            hlda        <= 1'b0;
            cur_t       <= TS_TRESET;
            busy        <= 1'b1;
            cyc_done    <= 1'b0;
            instr_out   <= '0;
            instr_valid <= 1'b0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            typ_q       <= typ_d;
            long_q      <= long_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            ALE         <= ale_d;
            RDn         <= rdn_d;
            WRn         <= wrn_d;
            {IOMn, S1, S0} <= sts_d;
            ad_oe       <= ad_oe_d;
            ad_out      <= ad_out_d;
            a_hi        <= a_hi_d;
            hlda        <= hlda_d;
            cur_t       <= cur_t_d;
            busy        <= busy_d;
            cyc_done    <= done_d;
            instr_valid <= cap_instr;
            rdata_valid <= cap_read;
            if (cap_instr) instr_out <= ad_in;
            if (cap_read)  rdata     <= ad_in;
        end
    end

    // Next-state and request latching
    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        typ_d     = typ_q;
        long_d    = long_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        last_q    = is_last_t(state_q, typ_q, long_q);
        accept    = cyc_start && cyc_type_legal(cyc_type) && !hlda
                    && ((state_q == ST_IDLE) || last_q);
        end_state = accept ? ST_T1 : (hold ? ST_THOLD : ST_IDLE);

        if (accept) begin
            typ_d   = cyc_type_e'(cyc_type);
            long_d  = cyc_long;
            addr_d  = cyc_addr;
            wdata_d = cyc_wdata;
        end

        case (state_q)
            ST_TRESET: begin
                if (rst_cnt_q == RST_CNT_W'(RESET_CYCLES - 1)) state_d = ST_IDLE;
                else rst_cnt_d = rst_cnt_q + RST_CNT_W'(1);
            end
            ST_IDLE:           state_d = end_state;
            ST_T1:             state_d = ST_T2;
            ST_T2, ST_TWAIT:   state_d = ready ? ST_T3 : ST_TWAIT;
            ST_T3:             state_d = (typ_q == CYC_M1) ? ST_T4 : end_state;
            ST_T4:             state_d = long_q ? ST_T5 : end_state;
            ST_T5:             state_d = ST_T6;
            ST_T6:             state_d = end_state;
            ST_THOLD:          state_d = hold ? ST_THOLD : ST_IDLE;
            default:           state_d = ST_TRESET;
        endcase
    end

    // Output decode from the upcoming state so outputs align with it once registered
    always_comb begin
        ale_d    = 1'b0;
        rdn_d    = 1'b1;
        wrn_d    = 1'b1;
        sts_d    = 3'b000;
        ad_oe_d  = 1'b0;
        ad_out_d = '0;
        a_hi_d   = '0;
        hlda_d   = 1'b0;
        cur_t_d  = TS_NONE;
        busy_d   = 1'b0;
        done_d   = is_last_t(state_d, typ_d, long_d);

        if (state_d inside {ST_T1, ST_T2, ST_TWAIT, ST_T3, ST_T4, ST_T5, ST_T6}) begin
            sts_d  = cyc_status(typ_d);
            // I/O cycles duplicate the 8-bit port number onto the high byte
            a_hi_d = cyc_is_io(typ_d) ? addr_d[AHI_W-1:0] : addr_d[ADDR_W-1 -: AHI_W];
            busy_d = 1'b1;
        end

        case (state_d)
            ST_TRESET: begin
                cur_t_d = TS_TRESET;
                busy_d  = 1'b1;
            end
            ST_T1: begin
                ale_d    = 1'b1;
                ad_oe_d  = 1'b1;
                ad_out_d = addr_d[DATA_W-1:0];
                cur_t_d  = TS_T1;
            end
            ST_T2, ST_TWAIT, ST_T3: begin
                cur_t_d = (state_d == ST_T3) ? TS_T3 : TS_T2;
                if (cyc_is_read(typ_d)) begin
                    rdn_d = 1'b0;
                end else begin
                    wrn_d    = 1'b0;
                    ad_oe_d  = 1'b1;
                    ad_out_d = wdata_d;
                end
            end
            ST_T4:    cur_t_d = TS_T4;
            ST_T5:    cur_t_d = TS_T5;
            ST_T6:    cur_t_d = TS_T6;
            ST_THOLD: hlda_d  = 1'b1;
            default:  ;
        endcase
    end

endmodule

// File: tb/tb_bus_cycle_unit.sv
// Directed bench for bus_cycle_unit: a vector table for whole bus cycles plus
// hand-written reset, hold and mid-cycle reset sequences.
module tb_bus_cycle_unit;

    localparam logic [6:0] C_T1 = 7'b1000000;
    localparam logic [6:0] C_T2 = 7'b0100000;
    localparam logic [6:0] C_T3 = 7'b0010000;
    localparam logic [6:0] C_T4 = 7'b0001000;
    localparam logic [6:0] C_T5 = 7'b0000100;
    localparam logic [6:0] C_T6 = 7'b0000010;
    localparam logic [6:0] C_RS = 7'b0000001;
    localparam logic [6:0] C_ID = 7'b0000000;
    localparam int NV = 26;

    logic        phi1 = 1'b0;
    logic        reset;
    logic        cyc_start;
    logic [2:0]  cyc_type;
    logic        cyc_long;
    logic [15:0] cyc_addr;
    logic [7:0]  cyc_wdata;
    logic [7:0]  ad_in;
    logic        ready;
    logic        hold;
    logic [7:0]  a_hi;
    logic [7:0]  ad_out;
    logic        ad_oe, ALE, RDn, WRn, IOMn, S0, S1, hlda;
    logic [6:0]  cur_t;
    logic [7:0]  instr_out;
    logic        instr_valid;
    logic [7:0]  rdata;
    logic        rdata_valid, cyc_done, busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        start;
        logic [2:0]  typ;
        logic        lng;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  adin;
        logic        rdy;
        logic [6:0]  e_t;
        logic        e_ale, e_rdn, e_wrn;
        logic [2:0]  e_sts;
        logic        e_oe;
        logic [7:0]  e_ahi, e_ado;
        logic        e_busy, e_done, e_rv, e_iv;
        logic [7:0]  e_dat;
    } vec_t;

    vec_t vecs [NV];

    bus_cycle_unit #(.RESET_CYCLES(3), .ADDR_W(16), .DATA_W(8)) dut (
        .phi1(phi1), .reset(reset), .cyc_start(cyc_start), .cyc_type(cyc_type),
        .cyc_long(cyc_long), .cyc_addr(cyc_addr), .cyc_wdata(cyc_wdata),
        .ad_in(ad_in), .ready(ready), .hold(hold), .a_hi(a_hi), .ad_out(ad_out),
        .ad_oe(ad_oe), .ALE(ALE), .RDn(RDn), .WRn(WRn), .IOMn(IOMn), .S0(S0),
        .S1(S1), .hlda(hlda), .cur_t(cur_t), .instr_out(instr_out),
        .instr_valid(instr_valid), .rdata(rdata), .rdata_valid(rdata_valid),
        .cyc_done(cyc_done), .busy(busy)
    );

    always #5 phi1 = ~phi1;

    task automatic tick();
        @(posedge phi1);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        reset = 1'b0; cyc_start = 1'b0; cyc_type = 3'd0; cyc_long = 1'b0;
        cyc_addr = 16'h0000; cyc_wdata = 8'h00; ad_in = 8'h00; ready = 1'b1; hold = 1'b0;

        // {start,typ,lng,addr,wdata,ad_in,ready | cur_t,ALE,RDn,WRn,{IOMn,S1,S0},oe,a_hi,ad_out,busy,done,rv,iv,data}
        vecs[0]  = '{1'b1,3'd1,1'b0,16'h1234,8'h00,8'hA5,1'b1, C_T1,1'b1,1'b1,1'b1,3'b010,1'b1,8'h12,8'h34,1'b1,1'b0,1'b0,1'b0,8'h00};
        vecs[1]  = '{1'b0,3'd1,1'b0,16'h1234,8'h00,8'hA5,1'b1, C_T2,1'b0,1'b0,1'b1,3'b010,1'b0,8'h12,8'h00,1'b1,1'b0,1'b0,1'b0,8'h00};
        vecs[2]  = '{1'b0,3'd1,1'b0,16'h1234,8'h00,8'hA5,1'b1, C_T3,1'b0,1'b0,1'b1,3'b010,1'b0,8'h12,8'h00,1'b1,1'b1,1'b0,1'b0,8'h00};
        vecs[3]  = '{1'b0,3'd1,1'b0,16'h1234,8'h00,8'hA5,1'b1, C_ID,1'b0,1'b1,1'b1,3'b000,1'b0,8'h00,8'h00,1'b0,1'b0,1'b1,1'b0,8'hA5};
        vecs[4]  = '{1'b1,3'd5,1'b0,16'hFFFF,8'h00,8'h00,1'b1, C_ID,1'b0,1'b1,1'b1,3'b000,1'b0,8'h00,8'h00,1'b0,1'b0,1'b0,1'b0,8'h00};
        vecs[5]  = '{1'b1,3'd0,1'b1,16'h2000,8'h00,8'h3E,1'b0, C_T1,1'b1,1'b1,1'b1,3'b011,1'b1,8'h20,8'h00,1'b1,1'b0,1'b0,1'b0,8'h00};
        vecs[6]  = '{1'b0,3'd0,1'b1,16'h2000,8'h00,8'h3E,1'b0, C_T2,1'b0,1'b0,1'b1,3'b011,1'b0,8'h20,8'h00,1'b1,1'b0,1'b0,1'b0,8'h00};
        vecs[7]  = '{1'b0,3'd0,1'b1,16'h2000,8'h00,8'h3E,1'b0, C_T2,1'b0,1'b0,1'b1,3'b011,1'b0,8'h20,8'h00,1'b1,1'b0,1'b0,1'b0,8'h00};
        vecs[8]  = '{1'b0,3'd0,1'b1,16'h2000,8'h00,8'h3E,1'b0, C_T2,1'b0,1'b0,1'b1,3'b011,1'b0,8'h20,8'h00,1'b1,1'b0,1'b0,1'b0,8'h00};
        vecs[9]  = '{1'b0,3'd0,1'b1,16'h2000,8'h00,8'h3E,1'b1, C_T3,1'b0,1'b0,1'b1,3'b011,1'b0,8'h20,8'h00,1'b1,1'b0,1'b0,1'b0,8'h00};
        vecs[10] = '{1'b0,3'd0,1'b1,16'h2000,8'h00,8'h3E,1'b1, C_T4,1'b0,1'b1,1'b1,3'b011,1'b0,8'h20,8'h00,1'b1,1'b0,1'b0,1'b1,8'h3E};
        vecs[11] = '{1'b0,3'd0,1'b1,16'h2000,8'h00,8'h3E,1'b1, C_T5,1'b0,1'b1,1'b1,3'b011,1'b0,8'h20,8'h00,1'b1,1'b0,1'b0,1'b0,8'h00};
        vecs[12] = '{1'b0,3'd0,1'b1,16'h2000,8'h00,8'h3E,1'b1, C_T6,1'b0,1'b1,1'b1,3'b011,1'b0,8'h20,8'h00,1'b1,1'b1,1'b0,1'b0,8'h00};
        vecs[13] = '{1'b1,3'd4,1'b0,16'h0042,8'h5A,8'h00,1'b1, C_T1,1'b1,1'b1,1'b1,3'b101,1'b1,8'h42,8'h42,1'b1,1'b0,1'b0,1'b0,8'h00};
        vecs[14] = '{1'b0,3'd4,1'b0,16'h0042,8'h5A,8'h00,1'b1, C_T2,1'b0,1'b1,1'b0,3'b101,1'b1,8'h42,8'h5A,1'b1,1'b0,1'b0,1'b0,8'h00};
        vecs[15] = '{1'b0,3'd4,1'b0,16'h0042,8'h5A,8'h00,1'b1, C_T3,1'b0,1'b1,1'b0,3'b101,1'b1,8'h42,8'h5A,1'b1,1'b1,1'b0,1'b0,8'h00};
        vecs[16] = '{1'b1,3'd3,1'b0,16'h0099,8'h00,8'h77,1'b1, C_T1,1'b1,1'b1,1'b1,3'b110,1'b1,8'h99,8'h99,1'b1,1'b0,1'b0,1'b0,8'h00};
        vecs[17] = '{1'b0,3'd3,1'b0,16'h0099,8'h00,8'h77,1'b1, C_T2,1'b0,1'b0,1'b1,3'b110,1'b0,8'h99,8'h00,1'b1,1'b0,1'b0,1'b0,8'h00};
        vecs[18] = '{1'b0,3'd3,1'b0,16'h0099,8'h00,8'h77,1'b1, C_T3,1'b0,1'b0,1'b1,3'b110,1'b0,8'h99,8'h00,1'b1,1'b1,1'b0,1'b0,8'h00};
        vecs[19] = '{1'b0,3'd3,1'b0,16'h0099,8'h00,8'h77,1'b1, C_ID,1'b0,1'b1,1'b1,3'b000,1'b0,8'h00,8'h00,1'b0,1'b0,1'b1,1'b0,8'h77};
        vecs[20] = '{1'b0,3'd3,1'b0,16'h0099,8'h00,8'h00,1'b1, C_ID,1'b0,1'b1,1'b1,3'b000,1'b0,8'h00,8'h00,1'b0,1'b0,1'b0,1'b0,8'h00};
        vecs[21] = '{1'b1,3'd0,1'b0,16'h0300,8'h00,8'h11,1'b1, C_T1,1'b1,1'b1,1'b1,3'b011,1'b1,8'h03,8'h00,1'b1,1'b0,1'b0,1'b0,8'h00};
        vecs[22] = '{1'b0,3'd0,1'b0,16'h0300,8'h00,8'h11,1'b1, C_T2,1'b0,1'b0,1'b1,3'b011,1'b0,8'h03,8'h00,1'b1,1'b0,1'b0,1'b0,8'h00};
        vecs[23] = '{1'b0,3'd0,1'b0,16'h0300,8'h00,8'h11,1'b1, C_T3,1'b0,1'b0,1'b1,3'b011,1'b0,8'h03,8'h00,1'b1,1'b0,1'b0,1'b0,8'h00};
        vecs[24] = '{1'b0,3'd0,1'b0,16'h0300,8'h00,8'h11,1'b1, C_T4,1'b0,1'b1,1'b1,3'b011,1'b0,8'h03,8'h00,1'b1,1'b1,1'b0,1'b1,8'h11};
        vecs[25] = '{1'b0,3'd0,1'b0,16'h0300,8'h00,8'h00,1'b1, C_ID,1'b0,1'b1,1'b1,3'b000,1'b0,8'h00,8'h00,1'b0,1'b0,1'b0,1'b0,8'h00};

        // Reset held two cycles, then three Treset cycles before idle
        tick();
        tick();
        chk("rst cur_t", 16'(cur_t), 16'(C_RS));
        chk("rst busy", 16'(busy), 16'(1'b1));
        chk("rst RDn/WRn/ALE/oe", 16'({RDn, WRn, ALE, ad_oe}), 16'(4'b1100));
        chk("rst status/hlda", 16'({IOMn, S1, S0, hlda}), 16'(4'b0000));
        chk("rst a_hi/ad_out", 16'({a_hi, ad_out}), 16'h0000);
        chk("rst data", 16'({instr_out, rdata}), 16'h0000);
        chk("rst pulses", 16'({instr_valid, rdata_valid, cyc_done}), 16'(3'b000));
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("release busy k%0d", k), 16'(busy), 16'(k < 2));
            chk($sformatf("release cur_t k%0d", k), 16'(cur_t), 16'((k < 2) ? C_RS : C_ID));
        end

        // Table-driven cycles: MR, illegal type, long M1 with waits, IOW, back-to-back IOR, short M1
        for (int i = 0; i < NV; i++) begin
            cyc_start = vecs[i].start; cyc_type = vecs[i].typ; cyc_long = vecs[i].lng;
            cyc_addr = vecs[i].addr; cyc_wdata = vecs[i].wdata; ad_in = vecs[i].adin;
            ready = vecs[i].rdy;
            tick();
            chk($sformatf("v%0d cur_t", i), 16'(cur_t), 16'(vecs[i].e_t));
            chk($sformatf("v%0d ALE/RDn/WRn", i), 16'({ALE, RDn, WRn}),
                16'({vecs[i].e_ale, vecs[i].e_rdn, vecs[i].e_wrn}));
            chk($sformatf("v%0d status", i), 16'({IOMn, S1, S0}), 16'(vecs[i].e_sts));
            chk($sformatf("v%0d ad_oe", i), 16'(ad_oe), 16'(vecs[i].e_oe));
            chk($sformatf("v%0d busy/done", i), 16'({busy, cyc_done}),
                16'({vecs[i].e_busy, vecs[i].e_done}));
            chk($sformatf("v%0d valids", i), 16'({rdata_valid, instr_valid}),
                16'({vecs[i].e_rv, vecs[i].e_iv}));
            if (vecs[i].e_t != C_ID) chk($sformatf("v%0d a_hi", i), 16'(a_hi), 16'(vecs[i].e_ahi));
            if (vecs[i].e_oe) chk($sformatf("v%0d ad_out", i), 16'(ad_out), 16'(vecs[i].e_ado));
            if (vecs[i].e_rv) chk($sformatf("v%0d rdata", i), 16'(rdata), 16'(vecs[i].e_dat));
            if (vecs[i].e_iv) chk($sformatf("v%0d instr_out", i), 16'(instr_out), 16'(vecs[i].e_dat));
        end
        chk("instr stable", 16'(instr_out), 16'h0011);

        // HOLD raised during MW T2 is deferred until the cycle completes
        cyc_start = 1'b1; cyc_type = 3'd2; cyc_addr = 16'h5000; cyc_wdata = 8'hC3; ready = 1'b1;
        tick();
        chk("mw T1 cur_t", 16'(cur_t), 16'(C_T1));
        chk("mw status", 16'({IOMn, S1, S0}), 16'(3'b001));
        cyc_start = 1'b0;
        tick();
        chk("mw T2 WRn/ad_out", 16'({WRn, ad_out}), 16'({1'b0, 8'hC3}));
        hold = 1'b1;
        tick();
        chk("mw T3 cur_t/done", 16'({cur_t, cyc_done}), 16'({C_T3, 1'b1}));
        chk("mw T3 hlda", 16'(hlda), 16'(1'b0));
        tick();
        chk("hold hlda", 16'(hlda), 16'(1'b1));
        chk("hold outputs", 16'({WRn, RDn, ad_oe, ALE, busy}), 16'(5'b11000));
        chk("hold cur_t", 16'(cur_t), 16'(C_ID));
        cyc_start = 1'b1; cyc_type = 3'd1; cyc_addr = 16'h6000; ad_in = 8'h5C;
        tick();
        chk("hold ignores start", 16'({hlda, cur_t}), 16'({1'b1, C_ID}));
        hold = 1'b0;
        tick();
        chk("hold release", 16'({hlda, cur_t, busy}), 16'({1'b0, C_ID, 1'b0}));
        tick();
        chk("post-hold T1", 16'({cur_t, ALE}), 16'({C_T1, 1'b1}));
        chk("post-hold a_hi", 16'(a_hi), 16'h0060);
        cyc_start = 1'b0;
        tick();
        tick();
        tick();
        chk("post-hold rdata", 16'({rdata_valid, rdata}), 16'({1'b1, 8'h5C}));

        // Reset during TWAIT abandons the read with no valid pulse
        cyc_start = 1'b1; cyc_type = 3'd1; cyc_addr = 16'h0F0F; ready = 1'b0; ad_in = 8'hEE;
        tick();
        cyc_start = 1'b0;
        tick();
        tick();
        chk("twait cur_t/RDn", 16'({cur_t, RDn}), 16'({C_T2, 1'b0}));
        reset = 1'b0;
        tick();
        chk("midrst cur_t", 16'(cur_t), 16'(C_RS));
        chk("midrst RDn/oe/busy", 16'({RDn, ad_oe, busy}), 16'(3'b101));
        chk("midrst rv", 16'(rdata_valid), 16'(1'b0));
        reset = 1'b1; ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("midrst k%0d rv", k), 16'(rdata_valid), 16'(1'b0));
            chk($sformatf("midrst k%0d busy", k), 16'(busy), 16'(k < 2));
        end
        chk("midrst rdata", 16'(rdata), 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
